// File: rtl/axi_slv_rd_arb.sv
// Round-robin arbiter that shares one in-order memory read port among several read controllers.
// Each issued request's owner is queued in a tag FIFO so results can be steered back in order.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module axi_slv_rd_arb #(
    parameter int REQ_NUM = 2,
    parameter int OST_NUM = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [REQ_NUM-1:0]                    rd_req_en,
    output logic [REQ_NUM-1:0]                    rd_req_ready,
    input  logic [REQ_NUM*`AXI_ADDR_WIDTH-1:0]    rd_base_addr,
    output logic [REQ_NUM-1:0]                    rd_result_en,
    output logic [`AXI_DATA_WIDTH-1:0]            rd_result_data,
    output logic                                  mem_rd_en,
    input  logic                                  mem_rd_ready,
    output logic [`AXI_ADDR_WIDTH-1:0]            mem_rd_addr,
    input  logic                                  mem_rd_vld,
    input  logic [`AXI_DATA_WIDTH-1:0]            mem_rd_data,
    output logic [$clog2(OST_NUM):0]              ost_cnt,
    output logic                                  err_unexp_rsp
);

    localparam int AW    = `AXI_ADDR_WIDTH;
    localparam int DW    = `AXI_DATA_WIDTH;
    localparam int IDX_W = $clog2(REQ_NUM);
    localparam int PTR_W = $clog2(OST_NUM) + 1;

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [IDX_W-1:0]   r_tag_mem [OST_NUM];
    logic [REQ_NUM-1:0] r_result_en;
    logic [DW-1:0]      r_result_data;
    logic               r_err;

    logic               w_gnt_vld;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [IDX_W-1:0]   w_cand;
    logic               w_empty;
    logic               w_full;
    logic               w_issue_ok;
    logic               w_issue;
    logic               w_pop;
    logic [IDX_W-1:0]   w_head_tag;
    logic [REQ_NUM-1:0] w_pop_onehot;
    logic [IDX_W-1:0]   w_rr_next;

    // Search from r_rr_ptr upwards, wrapping; the first active request wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = r_rr_ptr;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (!w_gnt_vld && rd_req_en[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
            w_cand = (w_cand == IDX_W'(REQ_NUM - 1)) ? '0 : w_cand + 1'b1;
        end
    end

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]) &&
                        (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]);
    assign w_issue_ok = mem_rd_ready & ~w_full;
    assign w_issue    = w_gnt_vld & w_issue_ok;
    // A pop only sees entries present before this cycle, so a same-cycle push cannot satisfy it.
    assign w_pop      = mem_rd_vld & ~w_empty;
    assign w_head_tag = r_tag_mem[r_rd_ptr[PTR_W-2:0]];
    assign w_rr_next  = (w_gnt_idx == IDX_W'(REQ_NUM - 1)) ? '0 : w_gnt_idx + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < REQ_NUM; gi++) begin : g_req
            assign rd_req_ready[gi] = w_issue & (w_gnt_idx == IDX_W'(gi));
            assign w_pop_onehot[gi] = w_pop & (w_head_tag == IDX_W'(gi));
        end
    endgenerate

    assign mem_rd_en      = w_issue;
    assign mem_rd_addr    = w_gnt_vld ? rd_base_addr[w_gnt_idx*AW +: AW] : '0;
    assign ost_cnt        = r_wr_ptr - r_rd_ptr;
    assign rd_result_en   = r_result_en;
    assign rd_result_data = r_result_data;
    assign err_unexp_rsp  = r_err;

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tag_mem[r_wr_ptr[PTR_W-2:0]] <= w_gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_result_en   <= '0;
            r_result_data <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rr_ptr <= w_rr_next;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr      <= r_rd_ptr + 1'b1;
                r_result_data <= mem_rd_data;
            end
            r_result_en <= w_pop_onehot;
            if (mem_rd_vld && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_slv_rd_arb.sv
// Directed bench for axi_slv_rd_arb: grant rotation, in-order result routing, flow control, errors.
module tb_axi_slv_rd_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_req_en;
    logic [1:0]  rd_req_ready;
    logic [63:0] rd_base_addr;
    logic [1:0]  rd_result_en;
    logic [31:0] rd_result_data;
    logic        mem_rd_en;
    logic        mem_rd_ready;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_vld;
    logic [31:0] mem_rd_data;
    logic [3:0]  ost_cnt;
    logic        err_unexp_rsp;

    int total = 0;
    int bad   = 0;

    axi_slv_rd_arb #(.REQ_NUM(2), .OST_NUM(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rd_req_en      (rd_req_en),
        .rd_req_ready   (rd_req_ready),
        .rd_base_addr   (rd_base_addr),
        .rd_result_en   (rd_result_en),
        .rd_result_data (rd_result_data),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_ready   (mem_rd_ready),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_vld     (mem_rd_vld),
        .mem_rd_data    (mem_rd_data),
        .ost_cnt        (ost_cnt),
        .err_unexp_rsp  (err_unexp_rsp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("chk %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic [1:0] exp_gnt;
        logic [1:0] issued [4];
        logic [1:0] tail_tags [3];

        rst_n        = 1'b0;
        rd_req_en    = '0;
        rd_base_addr = '0;
        mem_rd_ready = 1'b0;
        mem_rd_vld   = 1'b0;
        mem_rd_data  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(rd_req_ready), 64'h0);
        chk("rst_res_en", 64'(rd_result_en), 64'h0);
        chk("rst_res_data", 64'(rd_result_data), 64'h0);
        chk("rst_mem_en", 64'(mem_rd_en), 64'h0);
        chk("rst_mem_addr", 64'(mem_rd_addr), 64'h0);
        chk("rst_ost", 64'(ost_cnt), 64'h0);
        chk("rst_err", 64'(err_unexp_rsp), 64'h0);

        // single request from requester 0
        rd_base_addr = {32'h0000_0200, 32'h0000_0040};
        rd_req_en    = 2'b01;
        mem_rd_ready = 1'b1;
        #1;
        chk("t1_mem_en", 64'(mem_rd_en), 64'h1);
        chk("t1_addr", 64'(mem_rd_addr), 64'h40);
        chk("t1_ready", 64'(rd_req_ready), 64'h1);
        tick();
        rd_req_en = 2'b00;
        #1;
        chk("t1_ost1", 64'(ost_cnt), 64'h1);
        mem_rd_vld  = 1'b1;
        mem_rd_data = 32'hA5;
        #1;
        chk("t1_res_early", 64'(rd_result_en), 64'h0);
        tick();
        mem_rd_vld = 1'b0;
        chk("t1_res_en", 64'(rd_result_en), 64'h1);
        chk("t1_res_data", 64'(rd_result_data), 64'hA5);
        chk("t1_ost0", 64'(ost_cnt), 64'h0);
        tick();
        chk("t1_res_clr", 64'(rd_result_en), 64'h0);
        chk("t1_data_hold", 64'(rd_result_data), 64'hA5);

        // both requesting: rr pointer is 1 after the previous grant to 0
        rd_base_addr = {32'h0000_0200, 32'h0000_0100};
        rd_req_en    = 2'b11;
        exp_gnt      = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_ready", 64'(rd_req_ready), 64'(exp_gnt));
            chk("t2_addr", 64'(mem_rd_addr), (exp_gnt == 2'b10) ? 64'h200 : 64'h100);
            issued[i] = exp_gnt;
            exp_gnt   = ~exp_gnt;
            tick();
        end
        rd_req_en = 2'b00;
        for (int i = 0; i < 4; i++) begin
            mem_rd_vld  = 1'b1;
            mem_rd_data = 32'h10 + 32'(i);
            tick();
            chk("t2_res_en", 64'(rd_result_en), 64'(issued[i]));
            chk("t2_res_data", 64'(rd_result_data), 64'h10 + 64'(i));
        end
        mem_rd_vld = 1'b0;
        tick();
        chk("t2_ost0", 64'(ost_cnt), 64'h0);
        chk("t2_res_clr", 64'(rd_result_en), 64'h0);

        // fill the tag FIFO with requester 0 only
        rd_req_en = 2'b01;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t3_fill_ready", 64'(rd_req_ready), 64'h1);
            tick();
        end
        chk("t3_ost8", 64'(ost_cnt), 64'h8);
        chk("t3_full_ready", 64'(rd_req_ready), 64'h0);
        chk("t3_full_mem_en", 64'(mem_rd_en), 64'h0);
        mem_rd_vld  = 1'b1;
        mem_rd_data = 32'h77;
        tick();
        mem_rd_vld = 1'b0;
        #1;
        chk("t3_ost7", 64'(ost_cnt), 64'h7);
        chk("t3_res_en", 64'(rd_result_en), 64'h1);
        chk("t3_resume", 64'(rd_req_ready), 64'h1);
        tick();
        chk("t3_ost8b", 64'(ost_cnt), 64'h8);
        rd_req_en  = 2'b00;
        mem_rd_vld = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        mem_rd_vld = 1'b0;
        #1;
        chk("t3_drain", 64'(ost_cnt), 64'h0);

        // simultaneous push and pop at ost_cnt=3, tag order 0,1,0 then 1
        rd_req_en = 2'b01;
        tick();
        rd_req_en = 2'b10;
        tick();
        rd_req_en = 2'b01;
        tick();
        chk("t4_ost3", 64'(ost_cnt), 64'h3);
        rd_req_en   = 2'b10;
        mem_rd_vld  = 1'b1;
        mem_rd_data = 32'h31;
        #1;
        chk("t4_ready", 64'(rd_req_ready), 64'h2);
        tick();
        rd_req_en = 2'b00;
        chk("t4_ost_hold", 64'(ost_cnt), 64'h3);
        chk("t4_res0", 64'(rd_result_en), 64'h1);
        chk("t4_data0", 64'(rd_result_data), 64'h31);
        tail_tags[0] = 2'b10;
        tail_tags[1] = 2'b01;
        tail_tags[2] = 2'b10;
        for (int j = 0; j < 3; j++) begin
            mem_rd_data = 32'h32 + 32'(j);
            tick();
            chk("t4_res", 64'(rd_result_en), 64'(tail_tags[j]));
            chk("t4_data", 64'(rd_result_data), 64'h32 + 64'(j));
        end
        mem_rd_vld = 1'b0;
        tick();
        chk("t4_ost0", 64'(ost_cnt), 64'h0);

        // unexpected response, sticky error, reset with reads in flight
        mem_rd_vld  = 1'b1;
        mem_rd_data = 32'hEE;
        tick();
        mem_rd_vld = 1'b0;
        chk("t5_no_res", 64'(rd_result_en), 64'h0);
        chk("t5_err", 64'(err_unexp_rsp), 64'h1);
        chk("t5_data_kept", 64'(rd_result_data), 64'h34);
        tick();
        chk("t5_err_sticky", 64'(err_unexp_rsp), 64'h1);
        rd_req_en = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        rd_req_en = 2'b00;
        #1;
        chk("t5_ost4", 64'(ost_cnt), 64'h4);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ost", 64'(ost_cnt), 64'h0);
        chk("t5_rst_err", 64'(err_unexp_rsp), 64'h0);
        tick();
        rst_n      = 1'b1;
        mem_rd_vld = 1'b1;
        tick();
        mem_rd_vld = 1'b0;
        chk("t5_late_err", 64'(err_unexp_rsp), 64'h1);
        chk("t5_late_res", 64'(rd_result_en), 64'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // backpressure keeps rr pointer; req1 granted once memory is ready
        rd_req_en    = 2'b10;
        mem_rd_ready = 1'b0;
        #1;
        chk("t6_stall_ready", 64'(rd_req_ready), 64'h0);
        chk("t6_stall_mem_en", 64'(mem_rd_en), 64'h0);
        tick();
        tick();
        chk("t6_stall_ost", 64'(ost_cnt), 64'h0);
        mem_rd_ready = 1'b1;
        #1;
        chk("t6_gnt1", 64'(rd_req_ready), 64'h2);
        chk("t6_addr", 64'(mem_rd_addr), 64'h200);
        tick();
        rd_req_en = 2'b11;
        #1;
        chk("t6_rotate", 64'(rd_req_ready), 64'h1);
        tick();
        rd_req_en = 2'b00;
        #1;
        chk("t6_ost2", 64'(ost_cnt), 64'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
